// File: rtl/adam_pause_sequencer.sv
// adam_pause_sequencer
// Ordered pause/resume controller for the low-speed domain. Downstream
// targets are paused in ascending index order and released in descending
// order, one handshake at a time. A per-step monitor flags targets that
// take too long to answer. The sequencer keeps waiting after a timeout.
module adam_pause_sequencer #(
  parameter int NO_TGTS = 4,
  parameter int TIMEOUT = 255,
  localparam int IDX_W = (NO_TGTS > 1) ? $clog2(NO_TGTS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pause_req,
  output logic               pause_ack,
  output logic [NO_TGTS-1:0] tgt_req,
  input  logic [NO_TGTS-1:0] tgt_ack,
  output logic               busy,
  output logic               err,
  output logic [IDX_W-1:0]   err_idx,
  input  logic               err_clr
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NO_TGTS - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_PAUSING  = 2'd1,
    ST_PAUSED   = 2'd2,
    ST_RESUMING = 2'd3
  } state_t;

  state_t             state_r;
  logic [IDX_W-1:0]   idx_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               ack_cur_s;
  logic               step_done_s;
  logic               wait_s;
  logic               timeout_hit_s;

  // Request pattern with every target below index k asserted (thermometer code).
  function automatic logic [NO_TGTS-1:0] below_mask(input int k);
    logic [NO_TGTS-1:0] m;
    for (int j = 0; j < NO_TGTS; j++) begin
      m[j] = (j < k);
    end
    return m;
  endfunction

  // Decode whether the current step's awaited ack has arrived or is still pending.
  always_comb begin
    ack_cur_s     = tgt_ack[idx_r];
    step_done_s   = 1'b0;
    wait_s        = 1'b0;
    timeout_hit_s = 1'b0;
    case (state_r)
      ST_PAUSING: begin
        step_done_s = ack_cur_s;
        wait_s      = ~ack_cur_s;
      end
      ST_RESUMING: begin
        step_done_s = ~ack_cur_s;
        wait_s      = ack_cur_s;
      end
      default: begin
        step_done_s = 1'b0;
        wait_s      = 1'b0;
      end
    endcase
    if ((TIMEOUT > 0) && wait_s && (cnt_r == CNT_LAST)) begin
      timeout_hit_s = 1'b1;
    end else begin
      timeout_hit_s = 1'b0;
    end
  end

  // Sequencer: walks idx up while pausing and down while resuming; outputs are registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_PAUSED;
      idx_r     <= LAST_IDX;
      tgt_req   <= {NO_TGTS{1'b1}};
      pause_ack <= 1'b1;
      busy      <= 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (pause_req) begin
            state_r <= ST_PAUSING;
            idx_r   <= IDX_ZERO;
            tgt_req <= below_mask(1);
            busy    <= 1'b1;
          end
        end
        ST_PAUSING: begin
          if (step_done_s) begin
            if (!pause_req) begin
              // Reversal: release only what has been requested so far.
              state_r <= ST_RESUMING;
              tgt_req <= below_mask(int'(idx_r));
            end else if (idx_r == LAST_IDX) begin
              state_r   <= ST_PAUSED;
              tgt_req   <= {NO_TGTS{1'b1}};
              pause_ack <= 1'b1;
              busy      <= 1'b0;
            end else begin
              idx_r   <= idx_r + IDX_ONE;
              tgt_req <= below_mask(int'(idx_r) + 2);
            end
          end
        end
        ST_PAUSED: begin
          if (!pause_req) begin
            state_r <= ST_RESUMING;
            idx_r   <= LAST_IDX;
            tgt_req <= below_mask(NO_TGTS - 1);
            busy    <= 1'b1;
          end
        end
        ST_RESUMING: begin
          if (step_done_s) begin
            if (pause_req) begin
              // Reversal: re-request the target just released.
              state_r <= ST_PAUSING;
              tgt_req <= below_mask(int'(idx_r) + 1);
            end else if (idx_r == IDX_ZERO) begin
              state_r   <= ST_RUN;
              tgt_req   <= {NO_TGTS{1'b0}};
              pause_ack <= 1'b0;
              busy      <= 1'b0;
            end else begin
              idx_r   <= idx_r - IDX_ONE;
              tgt_req <= below_mask(int'(idx_r) - 1);
            end
          end
        end
        default: begin
          state_r   <= ST_PAUSED;
          idx_r     <= LAST_IDX;
          tgt_req   <= {NO_TGTS{1'b1}};
          pause_ack <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  // Step timer and sticky error capture; a new timeout beats a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r   <= {CNT_W{1'b0}};
      err     <= 1'b0;
      err_idx <= IDX_ZERO;
    end else begin
      if (wait_s) begin
        if (cnt_r != CNT_MAX) begin
          cnt_r <= cnt_r + CNT_ONE;
        end
      end else begin
        cnt_r <= {CNT_W{1'b0}};
      end
      if (timeout_hit_s) begin
        err <= 1'b1;
        if (!err || err_clr) begin
          err_idx <= idx_r;
        end
      end else if (err_clr) begin
        err     <= 1'b0;
        err_idx <= IDX_ZERO;
      end
    end
  end

endmodule

// File: tb/tb_adam_pause_sequencer.sv
// Testbench for adam_pause_sequencer: directed vector table, hand-written
// corner sequences and a randomized run against a level/direction model.
module tb_adam_pause_sequencer;
  localparam int N   = 4;
  localparam int TMO = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         pause_req;
  logic         pause_ack;
  logic [N-1:0] tgt_req;
  logic [N-1:0] tgt_ack;
  logic         busy;
  logic         err;
  logic [1:0]   err_idx;
  logic         err_clr;

  adam_pause_sequencer #(.NO_TGTS(N), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .pause_req(pause_req), .pause_ack(pause_ack),
    .tgt_req(tgt_req), .tgt_ack(tgt_ack), .busy(busy), .err(err),
    .err_idx(err_idx), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       pr;
    int         lat2;
    logic [3:0] req;
    logic       ack;
    logic       bsy;
  } vec_t;

  vec_t vecs[15];
  int   n_checks = 0;
  int   n_err = 0;
  int   lat[N];
  int   wt[N];
  bit   stuck[N];
  bit   mon_en = 1'b0;
  int   pa_changes = 0;

  // Reference model: number of requested targets, direction of travel, flags.
  int   m_level;
  bit   m_moving;
  bit   m_up;
  bit   m_ack;
  bit   m_err;
  int   m_err_idx;
  int   m_cnt;

  // Counts pause_ack transitions inside the async-reset window.
  always @(pause_ack) if (mon_en) pa_changes++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_level = N; m_moving = 1'b0; m_up = 1'b1; m_ack = 1'b1;
    m_err = 1'b0; m_err_idx = 0; m_cnt = 0;
  endtask

  task automatic model_step();
    int k;
    bit hit;
    k = 0;
    hit = 1'b0;
    if (!m_moving) begin
      m_cnt = 0;
      if (m_level == N && !pause_req) begin
        m_moving = 1'b1; m_up = 1'b0; m_level = N - 1;
      end else if (m_level == 0 && pause_req) begin
        m_moving = 1'b1; m_up = 1'b1; m_level = 1;
      end
    end else begin
      k = m_up ? m_level - 1 : m_level;
      if (tgt_ack[k] == m_up) begin
        m_cnt = 0;
        if (pause_req == m_up && (m_up ? (m_level == N) : (m_level == 0))) begin
          m_moving = 1'b0;
          m_ack = m_up;
        end else begin
          m_up = pause_req;
          m_level += m_up ? 1 : -1;
        end
      end else if (m_cnt < TMO) begin
        m_cnt++;
        hit = (m_cnt == TMO);
      end
    end
    if (hit) begin
      if (!m_err || err_clr) m_err_idx = k;
      m_err = 1'b1;
    end else if (err_clr) begin
      m_err = 1'b0;
      m_err_idx = 0;
    end
  endtask

  task automatic check_model();
    logic [N-1:0] e;
    for (int j = 0; j < N; j++) e[j] = (j < m_level);
    chk("model", {23'd0, tgt_req, pause_ack, busy, err, err_idx},
        {23'd0, e, m_ack, m_moving, m_err, 2'(m_err_idx)});
  endtask

  // Behavioural targets: ack follows req after lat[i] extra cycles unless stuck.
  task automatic update_targets();
    for (int i = 0; i < N; i++) begin
      if (!stuck[i]) begin
        if (tgt_req[i] != tgt_ack[i]) begin
          if (wt[i] >= lat[i]) begin
            tgt_ack[i] = tgt_req[i];
            wt[i] = 0;
          end else begin
            wt[i]++;
          end
        end else begin
          wt[i] = 0;
        end
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst) model_reset(); else model_step();
    @(negedge clk);
    check_model();
    update_targets();
  endtask

  initial begin
    bit hi_seen, saw_0001, done;

    vecs[0]  = '{1'b0, 0, 4'b0111, 1'b1, 1'b1};
    vecs[1]  = '{1'b0, 0, 4'b0011, 1'b1, 1'b1};
    vecs[2]  = '{1'b0, 0, 4'b0001, 1'b1, 1'b1};
    vecs[3]  = '{1'b0, 0, 4'b0000, 1'b1, 1'b1};
    vecs[4]  = '{1'b0, 0, 4'b0000, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 0, 4'b0000, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 3, 4'b0001, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 3, 4'b0011, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 3, 4'b0111, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 3, 4'b0111, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 3, 4'b0111, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 3, 4'b0111, 1'b0, 1'b1};
    vecs[12] = '{1'b1, 3, 4'b1111, 1'b0, 1'b1};
    vecs[13] = '{1'b1, 3, 4'b1111, 1'b1, 1'b0};
    vecs[14] = '{1'b1, 3, 4'b1111, 1'b1, 1'b0};

    rst = 1'b1; pause_req = 1'b1; err_clr = 1'b0; tgt_ack = '1;
    for (int i = 0; i < N; i++) begin lat[i] = 0; wt[i] = 0; stuck[i] = 1'b0; end
    model_reset();
    cycle(); cycle();
    rst = 1'b0;
    cycle(); cycle();
    chk("reset_pause_ack", pause_ack, 1'b1);
    chk("reset_tgt_req", tgt_req, 4'b1111);
    chk("reset_busy", busy, 1'b0);
    chk("reset_err", err, 1'b0);

    // Echo resume, then pause with target 2 acking late.
    for (int i = 0; i < 15; i++) begin
      pause_req = vecs[i].pr;
      lat[2] = vecs[i].lat2;
      cycle();
      chk("tbl_req", tgt_req, vecs[i].req);
      chk("tbl_ack", pause_ack, vecs[i].ack);
      chk("tbl_busy", busy, vecs[i].bsy);
    end

    // Reversal while pausing at idx 1.
    lat[2] = 0;
    pause_req = 1'b0;
    for (int i = 0; i < 6; i++) cycle();
    chk("rev_start_run", {pause_ack, busy, tgt_req}, 6'b000000);
    lat[1] = 3;
    pause_req = 1'b1;
    cycle(); cycle();
    chk("rev_idx1_req", tgt_req, 4'b0011);
    pause_req = 1'b0;
    hi_seen = 1'b0; saw_0001 = 1'b0; done = 1'b0;
    for (int n = 0; n < 20 && !done; n++) begin
      cycle();
      if (tgt_req[3:2] != 2'b00) hi_seen = 1'b1;
      if (tgt_req == 4'b0001) saw_0001 = 1'b1;
      if (!busy && tgt_req == 4'b0000) done = 1'b1;
    end
    chk("rev_done", done, 1'b1);
    chk("rev_hi_never", hi_seen, 1'b0);
    chk("rev_saw_0001", saw_0001, 1'b1);
    chk("rev_pause_ack", pause_ack, 1'b0);

    // Timeout on target 3.
    lat[1] = 0;
    stuck[3] = 1'b1;
    pause_req = 1'b1;
    for (int i = 0; i < 11; i++) cycle();
    chk("tmo_early", err, 1'b0);
    cycle();
    chk("tmo_err", err, 1'b1);
    chk("tmo_idx", err_idx, 2'd3);
    chk("tmo_busy", busy, 1'b1);
    for (int i = 0; i < 3; i++) cycle();
    chk("tmo_still_busy", {busy, err}, 2'b11);
    stuck[3] = 1'b0;
    cycle(); cycle();
    chk("tmo_paused", {pause_ack, busy, err}, 3'b101);
    err_clr = 1'b1;
    cycle();
    err_clr = 1'b0;
    chk("tmo_clr", {err, err_idx}, 3'b000);

    // Asynchronous reset in the middle of a resume.
    for (int i = 0; i < N; i++) lat[i] = 2;
    pause_req = 1'b0;
    cycle(); cycle(); cycle();
    chk("pre_rst_busy", busy, 1'b1);
    pa_changes = 0;
    mon_en = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("rst_async", {tgt_req, pause_ack, busy, err, err_idx}, 9'b1111_1_0_0_00);
    model_reset();
    cycle(); cycle();
    mon_en = 1'b0;
    chk("rst_no_glitch", pa_changes, 0);
    rst = 1'b0;

    // Randomized run against the model.
    for (int n = 0; n < 700; n++) begin
      if ($urandom_range(0, 7) == 0) pause_req = ~pause_req;
      if ($urandom_range(0, 15) == 0)
        lat[$urandom_range(0, N - 1)] = ($urandom_range(0, 9) == 0) ? 12 : int'($urandom_range(0, 3));
      err_clr = ($urandom_range(0, 19) == 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
